// File: rtl/soc_pkg.sv
// Shared SoC definitions: program-memory boot/patch FSM encoding and memory geometry defaults.
package soc_pkg;

    localparam int unsigned IMEM_ADDR_W = 8;
    localparam int unsigned IMEM_DATA_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

endpackage

// File: rtl/imem_boot_arbiter.sv
// Owns the program-memory port: streams a boot image in with the CPU held stopped, then
// arbitrates single-word patch writes against instruction fetch while the CPU runs.
module imem_boot_arbiter
    import soc_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              patch_valid,
    output logic              patch_ready,
    input  logic [ADDR_W-1:0] patch_addr,
    input  logic [DATA_W-1:0] patch_data,
    input  logic [ADDR_W-1:0] cpu_fetch_addr,
    output logic              cpu_run,
    output logic              cpu_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic [1:0]        state
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              overflow_q, overflow_d;
    logic              ld_fire;
    logic              ptr_at_end;

    assign ld_ready   = (state_q == ST_LOAD);
    assign cpu_run    = (state_q == ST_RUN);
    assign ld_fire    = ld_valid && ld_ready;
    assign ptr_at_end = (wr_ptr_q == {ADDR_W{1'b1}});

    assign word_count = word_count_q;
    assign overflow   = overflow_q;
    assign state      = state_q;

    // Patches win over fetch in RUN (CPU stalled) and are accepted freely while halted.
    always_comb begin
        patch_ready = 1'b0;
        cpu_stall   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            ST_LOAD: begin
                mem_we    = ld_fire;
                mem_addr  = wr_ptr_q;
                mem_wdata = ld_data;
            end
            ST_RUN: begin
                mem_addr = cpu_fetch_addr;
                if (patch_valid) begin
                    patch_ready = 1'b1;
                    cpu_stall   = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = patch_addr;
                    mem_wdata   = patch_data;
                end
            end
            ST_HALT: begin
                if (patch_valid) begin
                    patch_ready = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = patch_addr;
                    mem_wdata   = patch_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    wr_ptr_d     = '0;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (ld_fire) begin
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    word_count_d = word_count_q + 1'b1;
                    if (ld_last) begin
                        state_d = ST_RUN;
                    end else if (ptr_at_end) begin
                        // Image larger than memory: drop it and keep the CPU stopped.
                        state_d    = ST_IDLE;
                        overflow_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: doc/imem_boot_arbiter.md
# imem_boot_arbiter

- Owns the single write/read port of the SoC program memory and sequences the CPU around it.
- After reset it holds the CPU stopped, streams a program image from a loader into memory, then releases the CPU to fetch.
- While the CPU runs, it arbitrates single-word patch writes against instruction fetch by stalling the CPU one cycle per patch.
- Sits between `SoC` top-level program memory, the `cpu` instance and an external loader/debug port.

## Interface
Parameters:
- `ADDR_W`, 8: program memory word-address width; depth = 2**ADDR_W words.
- `DATA_W`, 32: instruction word width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `start`  in  1  level/pulse; begins image load from IDLE or HALT.
- `halt_req`  in  1  requests CPU stop while in RUN.
- `ld_valid`  in  1  loader beat valid.
- `ld_ready`  out  1  loader beat accepted when `ld_valid && ld_ready`.
- `ld_data`  in  DATA_W  loader word.
- `ld_last`  in  1  marks final word of image.
- `patch_valid`  in  1  patch write request.
- `patch_ready`  out  1  patch accepted this cycle.
- `patch_addr`  in  ADDR_W  patch word address.
- `patch_data`  in  DATA_W  patch word.
- `cpu_fetch_addr`  in  ADDR_W  CPU word address (pc>>2).
- `cpu_run`  out  1  1 = CPU out of reset and executing.
- `cpu_stall`  out  1  CPU must hold pc and suppress writeback this cycle.
- `mem_we`  out  1  program memory write enable.
- `mem_addr`  out  ADDR_W  program memory address.
- `mem_wdata`  out  DATA_W  program memory write data.
- `word_count`  out  ADDR_W+1  words written by last/current load.
- `overflow`  out  1  sticky: image exceeded depth.
- `state`  out  2  current FSM state.

## Operation
- States: IDLE, LOAD, RUN, HALT.
- IDLE: `cpu_run`=0. `start` → LOAD. Write pointer and `word_count` cleared on entry to LOAD. `overflow` cleared on entry to LOAD.
- LOAD:
  - `ld_ready`=1 (state decode).
  - Each accepted beat drives `mem_we`=1, `mem_addr`=wr_ptr, `mem_wdata`=`ld_data`, then increments wr_ptr and `word_count`.
  - Accepted beat with `ld_last`=1 → RUN.
  - Accepted beat at wr_ptr=2**ADDR_W-1 with `ld_last`=0 → set `overflow`, go to IDLE (image discarded; CPU not started).
  - `ld_last`=1 on the final address → RUN with `overflow`=0.
  - Patch port is ignored in LOAD (`patch_ready`=0).
- RUN:
  - `cpu_run`=1; `mem_addr`=`cpu_fetch_addr`, `mem_we`=0 by default.
  - `patch_valid`=1: same cycle `patch_ready`=1, `cpu_stall`=1, `mem_we`=1, `mem_addr`=`patch_addr`, `mem_wdata`=`patch_data`.
  - Back-to-back patches stall on consecutive cycles.
  - `halt_req` → HALT. If `halt_req` and `patch_valid` occur together, the patch is accepted first, then the FSM moves to HALT.
  - `start` and `ld_valid` are ignored in RUN.
- HALT:
  - `cpu_run`=0.
  - Patches are accepted every cycle with `cpu_stall`=0.
  - `start` → LOAD. If `start` and `patch_valid` occur together, the patch is written, then the FSM moves to LOAD.
- Memory contents are never cleared by this block.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - `state`=IDLE, `word_count`=0, `overflow`=0, `cpu_run`=0.
  - `cpu_stall`=0, `ld_ready`=0, `patch_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- State, wr_ptr, `word_count` and `overflow` are registered. `ld_ready`/`cpu_run` decode the state register only.
- `patch_ready`, `cpu_stall` and the `mem_*` outputs are combinational from state and request inputs. Memory samples them on the next rising edge, giving zero-cycle write latency.
- First cycle with `cpu_run`=1 is the cycle after the `ld_last` beat's handshake edge.
- `start` → `ld_ready`=1 one cycle later.
- `halt_req` → `cpu_run`=0 one cycle later.
- Reset asserted mid-LOAD or mid-RUN aborts immediately. Partially written memory remains. After release the FSM is in IDLE.
- `word_count` saturates naturally: max value 2**ADDR_W; width ADDR_W+1 avoids wrap.

## Structure
- Shared package `soc_pkg`: state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, HALT=2'd3) and the `ADDR_W`/`DATA_W` defaults reused by `SoC`.
- Single module; no sub-module. The write-pointer counter and FSM are small enough to live inline.

## Test plan
- Reset low, `start`, load 3 ADDI words ending with `ld_last` → memory[0..2] hold the words, `word_count`=3, `cpu_run`=1 the cycle after the third handshake, `mem_addr` follows `cpu_fetch_addr`.
- RUN with `patch_valid`, `patch_addr`=5, `patch_data`=32'h00A00293 → same cycle `cpu_stall`=1, `mem_we`=1, `mem_addr`=5; next cycle `cpu_stall`=0.
- ADDR_W=2: 4 beats without `ld_last` → `overflow`=1, state IDLE, `cpu_run` stays 0.
- Same-cycle `halt_req`+`patch_valid` in RUN → patch written, then `state`=HALT, `cpu_run`=0.
- Reset pulled low after 2 of 5 load beats → all outputs at reset values asynchronously. Restart load of 5 words → `word_count`=5.
- HALT, then `start`, then 1-word image with `ld_last` → `word_count`=1, `overflow`=0, RUN re-entered.
